ysyx_22040759_mem_arbiter: RTL and testbench
============================================

Name: ysyx_22040759_mem_arbiter

Overview:
Parametrised N-channel request arbiter. It merges the core's independent memory requesters onto a single downstream valid/ready memory port (AXI bridge side): instruction fetch, load/store, and future requesters such as a cache refill or DMA. It supports round-robin or fixed-priority selection and holds address, data and size stable for the whole transaction. A requester that abandons its request (pipeline flush) is drained safely.

Parameters:
N_CH, 2, number of requesting channels (2..8)
ADDR_W, 64, address width
DATA_W, 64, data width
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (channel 0 highest)
CNT_W, 32, width of the performance counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ch_valid  in  N_CH  per-channel request valid, held until ch_ready or withdrawn
ch_req  in  N_CH  per-channel direction, 1 = write, 0 = read
ch_addr  in  N_CH*ADDR_W  flattened addresses; channel i at [i*ADDR_W +: ADDR_W]
ch_wdata  in  N_CH*DATA_W  flattened write data
ch_size  in  N_CH*3  flattened access size (0=B, 1=H, 2=W, 3=D)
ch_ready  out  N_CH  one-cycle completion pulse to the granted channel
ch_rdata  out  DATA_W  read data, shared by all channels, valid with ch_ready
mem_valid  out  1  downstream request valid
mem_ready  in  1  downstream one-cycle completion pulse
mem_req  out  1  downstream direction
mem_addr  out  ADDR_W  downstream address
mem_wdata  out  DATA_W  downstream write data
mem_size  out  3  downstream size
grant  out  N_CH  one-hot owner of the current transaction; 0 when idle
busy_cycles  out  CNT_W  saturating count of cycles with mem_valid=1 and mem_ready=0

Behaviour:
- States: IDLE, BUSY, DRAIN. Reset is synchronous, active-high.
  - Reset → IDLE; grant=0, mem_valid=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_size=0, ch_ready=0, busy_cycles=0, rr_ptr=0.
  - Reset mid-transaction returns to IDLE immediately. Any outstanding downstream response that arrives later is ignored.
- IDLE:
  - If any ch_valid is set, select a winner.
  - RR_MODE=1: search starts at rr_ptr and wraps modulo N_CH.
  - RR_MODE=0: lowest index wins.
  - At the clock edge, register grant, req, addr, wdata and size of the winner, set mem_valid=1, and go to BUSY.
  - The arbitration decision takes one cycle, so mem_valid rises the cycle after ch_valid is first seen.
- BUSY:
  - mem_* outputs stay stable.
  - On mem_ready=1 with ch_valid[g]=1: ch_ready[g]=1 combinationally in the same cycle and ch_rdata=mem_rdata. The following apply at the edge:
    - mem_valid←0 and grant←0.
    - If RR_MODE=1, rr_ptr←(g+1) mod N_CH.
    - Go to IDLE.
  - If ch_valid[g]=0 and mem_ready=0 (withdrawn): go to DRAIN with mem_valid held at 1.
  - If ch_valid[g]=0 and mem_ready=1 in the same cycle: the response is discarded (no ch_ready). Go to IDLE and update rr_ptr as in a normal completion.
- DRAIN:
  - ch_ready stays 0.
  - On mem_ready: go to IDLE and update rr_ptr as in a normal completion.
  - Any new ch_valid is ignored until IDLE.
- Idle gap: at least one IDLE cycle separates consecutive downstream transactions. Back-to-back throughput is therefore one transaction per (latency+2) cycles.
- ch_ready is never asserted to a non-granted channel and never in IDLE or DRAIN.
- busy_cycles increments while mem_valid=1 and mem_ready=0. It saturates at all-ones and does not wrap.
- ch_rdata equals mem_rdata at all times; it is meaningful only when ch_ready is asserted.
- A write in flight is never cancelled downstream. Withdrawal only suppresses the upstream ch_ready.

Test Plan:
1. Reset, then ch_valid=2'b01 with addr 0x8000_0000 read size 3; mem_ready returned 3 cycles after mem_valid → mem_valid rises 1 cycle after ch_valid; ch_ready=2'b01 in the mem_ready cycle with rdata=0xDEAD_BEEF_0000_1234; then grant=0.
2. RR_MODE=1, both channels held valid continuously, mem_ready 1 cycle latency → grants alternate 01,10,01,10; each transaction separated by 1 IDLE cycle.
3. RR_MODE=0, both valid continuously → channel 0 wins every arbitration; channel 1 granted only after ch_valid[0] drops.
4. Channel 1 write to 0x8000_0100 wdata 0x55AA, size 2; ch_valid[1] dropped 1 cycle after grant, mem_ready 4 cycles later → DRAIN entered; mem_valid held with stable address/data; no ch_ready; IDLE after mem_ready.
5. Reset asserted in BUSY while mem_valid=1 → next cycle mem_valid=0, grant=0, busy_cycles=0; a late mem_ready produces no ch_ready.
6. CNT_W=4, downstream stalls 20 cycles → busy_cycles saturates at 15 and holds.

Source files
------------

// File: rtl/ysyx_22040759_mem_arbiter.sv
// ysyx_22040759_mem_arbiter
//
// Merges N_CH independent memory requesters onto one downstream valid/ready
// memory port. One transaction is in flight at a time. Its owner and its
// request fields are registered at grant and held until the downstream
// completion.
//
// Handshake: a requester raises ch_valid[i] with stable req/addr/wdata/size
// and holds them until ch_ready[i] pulses for one cycle (completion, with
// ch_rdata valid in that cycle), or drops ch_valid[i] to abandon the request.
// Downstream, mem_valid stays high with stable fields until mem_ready pulses
// for one cycle. mem_valid is never withdrawn once raised.
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   ch_valid/ch_req/ch_addr/ch_wdata/ch_size  per-channel requests (flattened)
//   ch_ready       one-cycle completion pulse to the granted channel
//   ch_rdata       read data (always mem_rdata; meaningful with ch_ready)
//   mem_valid/mem_req/mem_addr/mem_wdata/mem_size  downstream request
//   mem_ready      downstream completion pulse
//   mem_rdata      downstream read data
//   grant          one-hot owner of the current transaction, 0 when idle
//   busy_cycles    saturating count of stalled downstream cycles
//   fsm_state      current FSM state (0=IDLE, 1=BUSY, 2=DRAIN)
module ysyx_22040759_mem_arbiter #(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int RR_MODE = 1,
    parameter int CNT_W   = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CH-1:0]          ch_valid,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_wdata,
    input  logic [N_CH*3-1:0]        ch_size,
    output logic [N_CH-1:0]          ch_ready,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [2:0]               mem_size,
    output logic [N_CH-1:0]          grant,
    output logic [CNT_W-1:0]         busy_cycles,
    output logic [1:0]               fsm_state
);

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] owner_next;
    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    int               idx;

    // Winner search. Round-robin starts at rr_ptr and wraps; fixed priority
    // always starts at channel 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (RR_MODE != 0) ? ((int'(rr_ptr) + k) % N_CH) : k;
            if (!win_found && ch_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = idx[PTR_W-1:0];
            end
        end
    end

    // Pointer advances past the owner once its transaction finishes,
    // whether it was completed, discarded or drained.
    assign owner_next = (int'(owner) == N_CH - 1) ? '0 : owner + 1'b1;

    // ch_ready only to the owner, only in BUSY, and only if it still wants it.
    assign ch_ready  = (state == S_BUSY && mem_ready && ch_valid[owner]) ? grant : '0;
    assign ch_rdata  = mem_rdata;
    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            grant       <= '0;
            mem_valid   <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_size    <= '0;
            busy_cycles <= '0;
        end else begin
            if (mem_valid && !mem_ready && busy_cycles != {CNT_W{1'b1}})
                busy_cycles <= busy_cycles + 1'b1;

            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        owner     <= win_idx;
                        grant     <= N_CH'(1) << win_idx;
                        mem_valid <= 1'b1;
                        mem_req   <= ch_req[win_idx];
                        mem_addr  <= ch_addr[win_idx*ADDR_W +: ADDR_W];
                        mem_wdata <= ch_wdata[win_idx*DATA_W +: DATA_W];
                        mem_size  <= ch_size[win_idx*3 +: 3];
                        state     <= S_BUSY;
                    end
                end
                S_BUSY, S_DRAIN: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        grant     <= '0;
                        if (RR_MODE != 0) rr_ptr <= owner_next;
                        state     <= S_IDLE;
                    end else if (state == S_BUSY && !ch_valid[owner]) begin
                        // Abandoned: keep the downstream request alive until
                        // it completes, but never answer the requester.
                        state <= S_DRAIN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
module tb_ysyx_22040759_mem_arbiter;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   ch_valid = '0;
    logic [1:0]   ch_req = '0;
    logic [127:0] ch_addr = '0;
    logic [127:0] ch_wdata = '0;
    logic [5:0]   ch_size = '0;
    logic [63:0]  mem_rdata = '0;
    logic         mem_ready_a = 1'b0;
    logic         mem_ready_b = 1'b0;
    logic         sel = 1'b0;

    // Instance A: round-robin, 32-bit counter
    logic [1:0]  ch_ready_a, grant_a, state_a;
    logic [63:0] ch_rdata_a, mem_addr_a, mem_wdata_a;
    logic        mem_valid_a, mem_req_a;
    logic [2:0]  mem_size_a;
    logic [31:0] busy_a;

    // Instance B: fixed priority, 4-bit counter
    logic [1:0]  ch_ready_b, grant_b, state_b;
    logic [63:0] ch_rdata_b, mem_addr_b, mem_wdata_b;
    logic        mem_valid_b, mem_req_b;
    logic [2:0]  mem_size_b;
    logic [3:0]  busy_b;

    ysyx_22040759_mem_arbiter #(.N_CH(2), .ADDR_W(64), .DATA_W(64), .RR_MODE(1), .CNT_W(32)) dut_a (
        .clock(clock), .reset(reset), .ch_valid(ch_valid), .ch_req(ch_req),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_size(ch_size),
        .ch_ready(ch_ready_a), .ch_rdata(ch_rdata_a), .mem_valid(mem_valid_a),
        .mem_ready(mem_ready_a), .mem_rdata(mem_rdata), .mem_req(mem_req_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_size(mem_size_a),
        .grant(grant_a), .busy_cycles(busy_a), .fsm_state(state_a)
    );

    ysyx_22040759_mem_arbiter #(.N_CH(2), .ADDR_W(64), .DATA_W(64), .RR_MODE(0), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .ch_valid(ch_valid), .ch_req(ch_req),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_size(ch_size),
        .ch_ready(ch_ready_b), .ch_rdata(ch_rdata_b), .mem_valid(mem_valid_b),
        .mem_ready(mem_ready_b), .mem_rdata(mem_rdata), .mem_req(mem_req_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_size(mem_size_b),
        .grant(grant_b), .busy_cycles(busy_b), .fsm_state(state_b)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Selected instance view
    logic         s_valid;
    logic [1:0]   s_ready, s_grant, s_state;
    logic [63:0]  s_rdata, s_addr, s_wdata;
    logic [31:0]  s_busy;
    logic [133:0] s_txn;
    assign s_valid = sel ? mem_valid_b : mem_valid_a;
    assign s_ready = sel ? ch_ready_b : ch_ready_a;
    assign s_grant = sel ? grant_b : grant_a;
    assign s_state = sel ? state_b : state_a;
    assign s_rdata = sel ? ch_rdata_b : ch_rdata_a;
    assign s_addr  = sel ? mem_addr_b : mem_addr_a;
    assign s_wdata = sel ? mem_wdata_b : mem_wdata_a;
    assign s_busy  = sel ? {28'd0, busy_b} : busy_a;
    assign s_txn   = sel ? {grant_b, mem_req_b, mem_size_b, mem_addr_b, mem_wdata_b}
                         : {grant_a, mem_req_a, mem_size_a, mem_addr_a, mem_wdata_a};

    // ---------------- scoreboard ----------------
    logic [133:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ready(input logic v);
        if (sel) mem_ready_b = v;
        else     mem_ready_a = v;
    endtask

    task automatic push_txn(input logic [1:0] g, input logic r, input logic [2:0] sz,
                            input logic [63:0] a, input logic [63:0] d);
        exp_q.push_back({g, r, sz, a, d});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ch_valid = '0;
        mem_ready_a = 1'b0;
        mem_ready_b = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Wait (bounded) for the downstream request, then check it against the queue.
    task automatic wait_start();
        int n = 0;
        while (!s_valid && n < 10) begin
            tick();
            n++;
        end
        chk("start_timeout", s_valid, 1);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty observed=transaction expected=none");
        end else begin
            chk("txn", s_txn, exp_q.pop_front());
        end
    endtask

    task automatic serve(input int lat, input logic [1:0] exp_rdy, input logic [63:0] rd);
        wait_start();
        repeat (lat) tick();
        mem_rdata = rd;
        set_ready(1'b1);
        #1;
        chk("ch_ready", s_ready, exp_rdy);
        chk("ch_rdata", s_rdata, rd);
        tick();
        set_ready(1'b0);
        chk("idle_gap_valid", s_valid, 0);
        chk("idle_gap_grant", s_grant, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            chk("rst_valid", s_valid, 0);
            chk("rst_grant", s_grant, 0);
            chk("rst_busy", s_busy, 0);
            chk("rst_state", s_state, 0);
            chk("rst_txn", s_txn, 0);
        end

        // 1: single read on channel 0, 3-cycle downstream latency
        sel = 1'b0;
        ch_req = 2'b00;
        ch_addr = {64'h0, 64'h8000_0000};
        ch_size = {3'd0, 3'd3};
        ch_valid = 2'b01;
        push_txn(2'b01, 1'b0, 3'd3, 64'h8000_0000, 64'h0);
        tick();
        chk("t1_valid_latency", s_valid, 1);
        serve(3, 2'b01, 64'hDEAD_BEEF_0000_1234);
        ch_valid = 2'b00;
        chk("t1_busy_cycles", s_busy, 3);

        // 2: round-robin alternation with both channels held valid
        do_reset();
        ch_req = 2'b10;
        ch_addr = {64'h2000, 64'h1000};
        ch_wdata = {64'hABCD, 64'h0};
        ch_size = {3'd2, 3'd3};
        ch_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push_txn(2'b01, 1'b0, 3'd3, 64'h1000, 64'h0);
            else            push_txn(2'b10, 1'b1, 3'd2, 64'h2000, 64'hABCD);
        end
        for (int i = 0; i < 4; i++)
            serve(1, (i % 2 == 0) ? 2'b01 : 2'b10, 64'h100 + 64'(i));
        ch_valid = 2'b00;

        // 3: fixed priority, channel 0 always wins while valid
        do_reset();
        sel = 1'b1;
        ch_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            push_txn(2'b01, 1'b0, 3'd3, 64'h1000, 64'h0);
            serve(2, 2'b01, 64'h200 + 64'(i));
        end
        ch_valid = 2'b10;
        push_txn(2'b10, 1'b1, 3'd2, 64'h2000, 64'hABCD);
        serve(2, 2'b10, 64'h300);
        ch_valid = 2'b00;

        // 4: channel 1 write withdrawn -> DRAIN
        do_reset();
        sel = 1'b0;
        ch_addr = {64'h8000_0100, 64'h1000};
        ch_wdata = {64'h55AA, 64'h0};
        ch_valid = 2'b10;
        push_txn(2'b10, 1'b1, 3'd2, 64'h8000_0100, 64'h55AA);
        wait_start();
        tick();
        ch_valid = 2'b00;
        tick();
        chk("t4_state_drain", s_state, 2);
        for (int i = 0; i < 3; i++) begin
            chk("t4_drain_valid", s_valid, 1);
            chk("t4_drain_addr", s_addr, 64'h8000_0100);
            chk("t4_drain_wdata", s_wdata, 64'h55AA);
            if (i < 2) tick();
        end
        ch_valid = 2'b01;  // new request must be ignored during DRAIN
        set_ready(1'b1);
        #1;
        chk("t4_drain_no_ready", s_ready, 0);
        tick();
        set_ready(1'b0);
        chk("t4_back_idle", s_state, 0);
        chk("t4_idle_valid", s_valid, 0);
        // rr_ptr moved past channel 1, so channel 0 is next with both valid
        ch_valid = 2'b11;
        push_txn(2'b01, 1'b0, 3'd3, 64'h1000, 64'h0);
        serve(1, 2'b01, 64'h400);
        ch_valid = 2'b00;

        // 4b: withdrawal in the same cycle as mem_ready discards the response
        ch_valid = 2'b01;
        push_txn(2'b01, 1'b0, 3'd3, 64'h1000, 64'h0);
        wait_start();
        ch_valid = 2'b00;
        set_ready(1'b1);
        #1;
        chk("t4b_discard_ready", s_ready, 0);
        tick();
        set_ready(1'b0);
        chk("t4b_idle", s_state, 0);
        ch_valid = 2'b11;
        push_txn(2'b10, 1'b1, 3'd2, 64'h8000_0100, 64'h55AA);
        serve(1, 2'b10, 64'h500);
        ch_valid = 2'b00;

        // 5: reset while a transaction is outstanding
        do_reset();
        ch_valid = 2'b01;
        push_txn(2'b01, 1'b0, 3'd3, 64'h1000, 64'h0);
        wait_start();
        repeat (2) tick();
        chk("t5_busy_before", s_busy, 2);
        reset = 1'b1;
        tick();
        chk("t5_rst_valid", s_valid, 0);
        chk("t5_rst_grant", s_grant, 0);
        chk("t5_rst_busy", s_busy, 0);
        reset = 1'b0;
        ch_valid = 2'b00;
        set_ready(1'b1);
        #1;
        chk("t5_late_ready", s_ready, 0);
        tick();
        set_ready(1'b0);
        chk("t5_late_valid", s_valid, 0);

        // 6: 4-bit stall counter saturates at 15
        do_reset();
        sel = 1'b1;
        ch_addr = {64'h2000, 64'h1000};
        ch_valid = 2'b01;
        push_txn(2'b01, 1'b0, 3'd3, 64'h1000, 64'h0);
        wait_start();
        chk("t6_busy_start", s_busy, 0);
        repeat (14) tick();
        chk("t6_busy_14", s_busy, 14);
        tick();
        chk("t6_busy_15", s_busy, 15);
        repeat (5) tick();
        chk("t6_busy_hold", s_busy, 15);
        set_ready(1'b1);
        tick();
        set_ready(1'b0);
        ch_valid = 2'b00;
        chk("t6_busy_after", s_busy, 15);
        chk("t6_end_valid", s_valid, 0);

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
